// File: rtl/div_pkg.sv
// Shared types and defaults for the iterative restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_WIDTH    = 32;
    localparam int DIV_MAX_ITER = 32;

endpackage

// File: rtl/div_core.sv
// Restoring divider fed by the divisor-alignment stage; quotient to LO,
// remainder to HI, with DIV sign fix-up applied in a final cycle.
module div_core
    import div_pkg::*;
#(
    parameter int WIDTH    = DIV_WIDTH,
    parameter int MAX_ITER = DIV_MAX_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dvdnd,
    input  logic [WIDTH-1:0] dvsr,
    input  logic [WIDTH-1:0] shiftb,
    input  logic             q_neg,
    input  logic             r_neg,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic             err,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int IW = $clog2(MAX_ITER + 1);
    localparam logic [IW-1:0] ITER_LAST = IW'(MAX_ITER - 1);

    div_state_t state, state_nxt;

    logic [WIDTH-1:0] dvsr_r, dvsr_nxt;
    logic [WIDTH-1:0] rem_acc, rem_acc_nxt;
    logic [WIDTH-1:0] cur, cur_nxt;
    logic [WIDTH-1:0] q_acc, q_acc_nxt;
    logic [WIDTH-1:0] quot_nxt, rem_nxt;
    logic [IW-1:0]    iter, iter_nxt;
    logic             q_neg_r, q_neg_nxt;
    logic             r_neg_r, r_neg_nxt;
    logic             div0_nxt, err_nxt, done_nxt;
    logic             fits;
    logic [WIDTH-1:0] diff;

    assign fits = rem_acc >= cur;
    assign diff = rem_acc - cur;
    assign busy = (state == RUN) || (state == FIX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        dvsr_nxt    = dvsr_r;
        q_neg_nxt   = q_neg_r;
        r_neg_nxt   = r_neg_r;
        rem_acc_nxt = rem_acc;
        cur_nxt     = cur;
        q_acc_nxt   = q_acc;
        iter_nxt    = iter;
        quot_nxt    = quot;
        rem_nxt     = rem;
        div0_nxt    = div0;
        err_nxt     = err;
        done_nxt    = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    dvsr_nxt    = dvsr;
                    q_neg_nxt   = q_neg;
                    r_neg_nxt   = r_neg;
                    rem_acc_nxt = dvdnd;
                    cur_nxt     = shiftb;
                    q_acc_nxt   = '0;
                    iter_nxt    = '0;
                    div0_nxt    = 1'b0;
                    err_nxt     = 1'b0;
                    if (dvsr == '0) begin
                        div0_nxt  = 1'b1;
                        q_acc_nxt = '1;
                        state_nxt = FIX;
                    end else if (dvsr > dvdnd) begin
                        // shiftb is meaningless here, so skip the loop
                        state_nxt = FIX;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (fits) begin
                    rem_acc_nxt = diff;
                    q_acc_nxt   = {q_acc[WIDTH-2:0], 1'b1};
                end else begin
                    q_acc_nxt   = {q_acc[WIDTH-2:0], 1'b0};
                end
                if (cur == dvsr_r) begin
                    state_nxt = FIX;
                end else if (iter == ITER_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = FIX;
                end else begin
                    cur_nxt  = cur >> 1;
                    iter_nxt = iter + 1'b1;
                end
            end
            FIX: begin
                if (div0) begin
                    quot_nxt = q_acc;
                    rem_nxt  = rem_acc;
                end else begin
                    quot_nxt = q_neg_r ? -q_acc : q_acc;
                    rem_nxt  = r_neg_r ? -rem_acc : rem_acc;
                end
                done_nxt  = 1'b1;
                state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvsr_r  <= '0;
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
            rem_acc <= '0;
            cur     <= '0;
            q_acc   <= '0;
            iter    <= '0;
            quot    <= '0;
            rem     <= '0;
            div0    <= 1'b0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            dvsr_r  <= dvsr_nxt;
            q_neg_r <= q_neg_nxt;
            r_neg_r <= r_neg_nxt;
            rem_acc <= rem_acc_nxt;
            cur     <= cur_nxt;
            q_acc   <= q_acc_nxt;
            iter    <= iter_nxt;
            quot    <= quot_nxt;
            rem     <= rem_nxt;
            div0    <= div0_nxt;
            err     <= err_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_div_core.sv
// Directed bench for div_core: signs, short cases, guard, busy start, reset.
module tb_div_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dvdnd = '0;
    logic [31:0] dvsr = '0;
    logic [31:0] shiftb = '0;
    logic        q_neg = 1'b0;
    logic        r_neg = 1'b0;
    logic        busy, done, div0, err;
    logic [31:0] quot, rem;

    int tests = 0;
    int fails = 0;
    int lat;

    div_core dut (
        .clk(clk), .rst(rst), .start(start),
        .dvdnd(dvdnd), .dvsr(dvsr), .shiftb(shiftb),
        .q_neg(q_neg), .r_neg(r_neg),
        .busy(busy), .done(done), .div0(div0), .err(err),
        .quot(quot), .rem(rem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle 0 is the start cycle; returns the cycle done is seen in, or -1.
    // A non-zero poke re-asserts start (with a div0 operand) in that cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] sb, input logic qn,
                          input logic rn, input int poke,
                          output int cyc);
        @(negedge clk);
        dvdnd = a; dvsr = b; shiftb = sb; q_neg = qn; r_neg = rn;
        start = 1'b1;
        @(posedge clk);
        cyc = -1;
        for (int n = 1; n < 100; n++) begin
            @(negedge clk);
            start = (n == poke);
            if (n == poke) begin
                dvsr  = '0;
                dvdnd = 32'h1234;
            end else begin
                dvdnd = 32'hA5A5_A5A5;
                dvsr  = 32'h5A5A_5A5A;
                shiftb = 32'h0F0F_0F0F;
            end
            if (done) begin
                cyc = n;
                break;
            end
            @(posedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quot", quot, 32'd0);
        chk("rst_rem", rem, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'd100, 32'd7, 32'd56, 1'b0, 1'b0, 0, lat);
        chk("divu_lat", lat, 32'd6);
        chk("divu_quot", quot, 32'd14);
        chk("divu_rem", rem, 32'd2);
        chk("divu_flags", {30'd0, div0, err}, 32'd0);
        chk("divu_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("divu_pulse", {31'd0, done}, 32'd0);

        run_op(32'd100, 32'd7, 32'd56, 1'b1, 1'b1, 0, lat);
        chk("div_lat", lat, 32'd6);
        chk("div_quot", quot, 32'hFFFF_FFF2);
        chk("div_rem", rem, 32'hFFFF_FFFE);

        run_op(32'h1234, 32'd0, 32'd0, 1'b1, 1'b1, 0, lat);
        chk("dz_lat", lat, 32'd2);
        chk("dz_div0", {31'd0, div0}, 32'd1);
        chk("dz_quot", quot, 32'hFFFF_FFFF);
        chk("dz_rem", rem, 32'h1234);

        run_op(32'd5, 32'd9, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, lat);
        chk("gt_lat", lat, 32'd2);
        chk("gt_div0", {31'd0, div0}, 32'd0);
        chk("gt_quot", quot, 32'd0);
        chk("gt_rem", rem, 32'd5);

        run_op(32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 0, lat);
        chk("full_lat", lat, 32'd34);
        chk("full_quot", quot, 32'hFFFF_FFFF);
        chk("full_rem", rem, 32'd0);
        chk("full_err", {31'd0, err}, 32'd0);

        run_op(32'd100, 32'd7, 32'd3, 1'b0, 1'b0, 0, lat);
        chk("bad_lat", lat, 32'd34);
        chk("bad_err", {31'd0, err}, 32'd1);
        chk("bad_div0", {31'd0, div0}, 32'd0);
        @(negedge clk);
        chk("bad_pulse", {31'd0, done}, 32'd0);
        chk("bad_hold", {31'd0, err}, 32'd1);

        run_op(32'd100, 32'd7, 32'd56, 1'b0, 1'b0, 2, lat);
        chk("busy_lat", lat, 32'd6);
        chk("busy_quot", quot, 32'd14);
        chk("busy_rem", rem, 32'd2);
        chk("busy_div0", {31'd0, div0}, 32'd0);
        @(negedge clk);
        chk("busy_after", {31'd0, busy}, 32'd0);

        @(negedge clk);
        dvdnd = 32'd100; dvsr = 32'd7; shiftb = 32'd56;
        q_neg = 1'b0; r_neg = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("ar_busy_pre", {31'd0, busy}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_done", {31'd0, done}, 32'd0);
        chk("ar_quot", quot, 32'd0);
        chk("ar_rem", rem, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("ar_nodone", {31'd0, done}, 32'd0);
        end

        run_op(32'd100, 32'd7, 32'd56, 1'b0, 1'b0, 0, lat);
        chk("rec_lat", lat, 32'd6);
        chk("rec_quot", quot, 32'd14);
        chk("rec_rem", rem, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
